mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-port data block RAM between two requesters: the CPU load/store path (driven by the multicycle control FSM) and the I/O peripheral port (keypad/display/DMA side). Accepts one request at a time through a level request / one-cycle acknowledge handshake, drives the RAM address, write data and write enable for exactly one cycle per transaction, and returns registered read data. Sits between the controller/datapath, the peripheral bus and the block RAM.

## Interface
Parameters:
- ADDR_W, 16, RAM word address width
- DATA_W, 16, RAM data width

Ports:
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-low
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- io_req, io_we, io_addr, io_wdata  in  1/1/ADDR_W/DATA_W  same meaning for I/O requester
- io_ack  out  1  one-cycle completion pulse to I/O
- rdata  out  DATA_W  read data, valid in the ack cycle, held until next read completes
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, one-cycle registered latency
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req high, pick winner, latch owner, we, addr, wdata; go ISSUE. Otherwise stay.
- ISSUE: mem_addr = latched addr, mem_wdata = latched wdata, mem_we = latched we. Write -> ACK; read -> WAIT.
- WAIT: capture mem_rdata into rdata; go ACK.
- ACK: owner's ack = 1 for this cycle only; go IDLE.
- Outside ISSUE: mem_we = 0; mem_addr, mem_wdata hold latched values.
- Requests are sampled only in IDLE; a request arriving while busy waits and is not lost.
- Requester must drop req on the edge where it sees ack; req high in a later IDLE is a new transaction.
- Both req high in IDLE: arbitration per Configuration.
- Inputs changing after latch have no effect on the transaction in flight.

## Timing
- Reset (reset = 0 at an edge): state IDLE, cpu_ack = io_ack = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, busy = 0, last-owner = I/O.
- Write: req seen in IDLE cycle N, mem_we high cycle N+1, ack cycle N+2.
- Read: req seen cycle N, mem_addr driven N+1, rdata captured N+2, ack and rdata valid N+3.
- Back-to-back: minimum 1 IDLE cycle between transactions; write throughput 1 per 3 cycles, read 1 per 4.
- Reset during ISSUE of a write: the RAM commits the write on that edge; no ack is issued. Reset in any other state aborts with no memory side effect and no ack.
- At most one of cpu_ack, io_ack high in any cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On simultaneous requests the requester not served last wins; last-owner updated in ACK. First tie after reset goes to CPU.
- Not defined: fixed priority, CPU always wins ties; I/O may starve under continuous CPU traffic. last-owner register omitted.

## Test plan
- CPU write addr 0x0010 data 0xBEEF from IDLE -> mem_we high only in cycle N+1 with addr 0x0010/data 0xBEEF, cpu_ack at N+2, io_ack stays 0.
- I/O read of 0x0010 after above -> io_ack at N+3 with rdata = 0xBEEF, mem_we never high.
- Both req in same IDLE cycle, repeated 4 transactions -> without macro all CPU until cpu_req drops; with MEM_ARB_RR_EN grants CPU, I/O, CPU, I/O.
- io_req asserted during CPU read WAIT -> I/O transaction starts in first IDLE after cpu_ack, no ack overlap.
- reset = 0 during WAIT of a read -> next cycle state IDLE, no ack, all outputs at reset values; reset during ISSUE of write 0x1234 to 0x0020 -> later read of 0x0020 returns 0x1234, no cpu_ack for the write.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port data RAM (CPU load/store path and I/O port).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU wins every tie.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t              state_reg, state_next;
  logic                owner_reg, owner_next;   // 0 = CPU, 1 = I/O
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                pick_io;

`ifdef MEM_ARB_RR_EN
  logic last_reg, last_next;                    // owner of the last acked transaction
  assign pick_io = io_req & (~cpu_req | ~last_reg);
`else
  assign pick_io = io_req & ~cpu_req;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
`ifdef MEM_ARB_RR_EN
      last_reg  <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
`ifdef MEM_ARB_RR_EN
      last_reg  <= last_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
`ifdef MEM_ARB_RR_EN
    last_next  = last_reg;
`endif
    mem_we     = 1'b0;
    cpu_ack    = 1'b0;
    io_ack     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_req || io_req) begin
          owner_next = pick_io;
          we_next    = pick_io ? io_we    : cpu_we;
          addr_next  = pick_io ? io_addr  : cpu_addr;
          wdata_next = pick_io ? io_wdata : cpu_wdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_we     = we_reg;
        state_next = we_reg ? ACK : WAIT;
      end
      WAIT: begin
        rdata_next = mem_rdata;
        state_next = ACK;
      end
      ACK: begin
        cpu_ack    = ~owner_reg;
        io_ack     = owner_reg;
`ifdef MEM_ARB_RR_EN
        last_next  = owner_reg;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and data stay parked on the latched values between transactions.
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata     = rdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule
